// File: rtl/ex_mdu.sv
// Iterative RISC-V M-extension multiply/divide unit for the EX stage.
// Optional single-cycle multiplier: define MDU_FAST_MUL_EN.
module ex_mdu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            stall_req,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = '1;

    typedef enum logic [1:0] {IDLE, BUSY, FAST, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg, count_next;
    logic [XLEN-1:0] hi_reg, hi_next;
    logic [XLEN-1:0] lo_reg, lo_next;
    logic [XLEN-1:0] opnd_reg, opnd_next;
    logic [XLEN-1:0] result_reg, result_next;
    logic [2:0]      op_reg, op_next;
    logic            neg_reg, neg_next;

    // Operand decode for the incoming instruction
    logic            sign_a, sign_b, new_neg;
    logic [XLEN-1:0] mag_a, mag_b;
    logic            div_by_zero, div_ovf;
    logic [XLEN-1:0] special_result;

    always_comb begin
        if (op[2]) begin
            sign_a = a[XLEN-1] & ~op[0];
            sign_b = b[XLEN-1] & ~op[0];
        end else begin
            sign_a = a[XLEN-1] & (op[1:0] != 2'b11);
            sign_b = b[XLEN-1] & ~op[1];
        end
        mag_a = sign_a ? (~a + 1'b1) : a;
        mag_b = sign_b ? (~b + 1'b1) : b;
        // Remainder follows the dividend only; everything else uses xor of signs
        if (op[2] && op[1])
            new_neg = sign_a;
        else
            new_neg = sign_a ^ sign_b;
        div_by_zero = (b == '0);
        div_ovf     = ~op[0] && (a == INT_MIN) && (b == ALL_ONES);
        if (div_by_zero)
            special_result = op[1] ? a : ALL_ONES;
        else
            special_result = op[1] ? '0 : INT_MIN;
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_mag_prod, fast_prod;
    logic [XLEN-1:0]   fast_mul_result;
    assign fast_mag_prod   = mag_a * mag_b;
    assign fast_prod       = new_neg ? (~fast_mag_prod + 1'b1) : fast_mag_prod;
    assign fast_mul_result = (op[1:0] == 2'b00) ? fast_prod[XLEN-1:0]
                                                : fast_prod[2*XLEN-1:XLEN];
`endif

    // One shift-add or restoring-divide step on the current accumulators
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift, div_diff;
    logic [XLEN-1:0]   iter_hi, iter_lo;
    logic [2*XLEN-1:0] prod_mag, prod_signed;
    logic [XLEN-1:0]   quo_signed, rem_signed, final_result;

    always_comb begin
        mul_sum   = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, opnd_reg} : '0);
        div_shift = {hi_reg, lo_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, opnd_reg};
        if (op_reg[2]) begin
            if (!div_diff[XLEN]) begin
                iter_hi = div_diff[XLEN-1:0];
                iter_lo = {lo_reg[XLEN-2:0], 1'b1};
            end else begin
                iter_hi = div_shift[XLEN-1:0];
                iter_lo = {lo_reg[XLEN-2:0], 1'b0};
            end
        end else begin
            iter_hi = mul_sum[XLEN:1];
            iter_lo = {mul_sum[0], lo_reg[XLEN-1:1]};
        end

        prod_mag    = {iter_hi, iter_lo};
        prod_signed = neg_reg ? (~prod_mag + 1'b1) : prod_mag;
        quo_signed  = neg_reg ? (~iter_lo + 1'b1) : iter_lo;
        rem_signed  = neg_reg ? (~iter_hi + 1'b1) : iter_hi;

        if (op_reg[2])
            final_result = op_reg[1] ? rem_signed : quo_signed;
        else if (op_reg[1:0] == 2'b00)
            final_result = prod_signed[XLEN-1:0];
        else
            final_result = prod_signed[2*XLEN-1:XLEN];
    end

    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        hi_next     = hi_reg;
        lo_next     = lo_reg;
        opnd_next   = opnd_reg;
        result_next = result_reg;
        op_next     = op_reg;
        neg_next    = neg_reg;

        if (flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        op_next  = op;
                        neg_next = new_neg;
                        if (op[2] && (div_by_zero || div_ovf)) begin
                            state_next = FAST;
                            hi_next    = '0;
                            lo_next    = special_result;
                        end
`ifdef MDU_FAST_MUL_EN
                        else if (!op[2]) begin
                            state_next = FAST;
                            hi_next    = '0;
                            lo_next    = fast_mul_result;
                        end
`endif
                        else begin
                            state_next = BUSY;
                            count_next = '0;
                            hi_next    = '0;
                            lo_next    = op[2] ? mag_a : mag_b;
                            opnd_next  = op[2] ? mag_b : mag_a;
                        end
                    end
                end
                BUSY: begin
                    hi_next    = iter_hi;
                    lo_next    = iter_lo;
                    count_next = count_reg + 1'b1;
                    if (count_reg == CW'(XLEN-1)) begin
                        state_next  = DONE;
                        result_next = final_result;
                    end
                end
                FAST: begin
                    state_next  = DONE;
                    result_next = lo_reg;
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            opnd_reg   <= '0;
            result_reg <= '0;
            op_reg     <= '0;
            neg_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            hi_reg     <= hi_next;
            lo_reg     <= lo_next;
            opnd_reg   <= opnd_next;
            result_reg <= result_next;
            op_reg     <= op_next;
            neg_reg    <= neg_next;
        end
    end

    assign done      = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign result    = result_reg;
    assign stall_req = start & ~done;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed self-checking bench for ex_mdu: results, latency, stall, flush, reset.
module tb_ex_mdu;

    localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT  = 33;
    localparam int FAST_LAT = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic            flush;
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] a, b;
    logic            stall_req, busy, done;
    logic [XLEN-1:0] result;

    int n_vec = 0;
    int n_fail = 0;

    ex_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
        .a(a), .b(b), .stall_req(stall_req), .busy(busy), .done(done),
        .result(result)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Caller is 1 time unit after a rising edge with the unit idle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        logic stall_ok;
        lat = 0;
        stall_ok = 1'b1;
        op = o; a = x; b = y; start = 1'b1;
        #1;
        if (stall_req !== 1'b1) stall_ok = 1'b0;
        for (int c = 1; c <= 100 && lat == 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                a = ~x;
                b = x ^ y;
            end
            if (done === 1'b1) lat = c;
            else if (stall_req !== 1'b1) stall_ok = 1'b0;
        end
        check({tag, " latency"}, lat, exp_lat);
        check({tag, " result"}, result, exp_res);
        check({tag, " stall_done"}, {31'd0, stall_req}, 32'd0);
        check({tag, " stall_before"}, {31'd0, stall_ok}, 32'd1);
        $display("op=%0d a=0x%08h b=0x%08h -> result=0x%08h latency=%0d (%s)",
                 o, x, y, result, lat, tag);
        // start still high through DONE: must not be recaptured
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " idle_after"}, {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        rst = 1'b1; flush = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
        #12;
        check("reset outputs", {29'd0, busy, done, stall_req}, 32'd0);
        check("reset result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op("MUL -1*3",      3'b000, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD, MUL_LAT);
        run_op("MULHU",         3'b011, 32'hFFFFFFFF, 32'h00000003, 32'h00000002, MUL_LAT);
        run_op("MULHSU",        3'b010, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFF, MUL_LAT);
        run_op("MULH min*min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        run_op("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, DIV_LAT);
        run_op("REM -7%2",      3'b110, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, DIV_LAT);
        run_op("DIVU 100/7",    3'b101, 32'd100,      32'd7,        32'd14,       DIV_LAT);
        run_op("REMU 100%7",    3'b111, 32'd100,      32'd7,        32'd2,        DIV_LAT);
        run_op("DIVU 5/0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, FAST_LAT);
        run_op("REMU 9%0",      3'b111, 32'd9,        32'd0,        32'd9,        FAST_LAT);
        run_op("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        FAST_LAT);
        run_op("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, FAST_LAT);

        // Flush a DIV after 10 iterations
        op = 3'b100; a = 32'd1000; b = 32'd3; start = 1'b1;
        begin
            logic saw_done;
            saw_done = 1'b0;
            for (int c = 1; c <= 11; c++) begin
                @(posedge clk); #1;
                if (done === 1'b1) saw_done = 1'b1;
            end
            flush = 1'b1;
            @(posedge clk); #1;
            if (done === 1'b1) saw_done = 1'b1;
            flush = 1'b0;
            check("flush no done", {31'd0, saw_done}, 32'd0);
        end
        check("flush idle", {30'd0, busy, done}, 32'd0);
        check("flush stall follows start hi", {31'd0, stall_req}, 32'd1);
        check("flush result held", result, 32'h80000000);
        start = 1'b0;
        #1;
        check("flush stall follows start lo", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        run_op("MULHU max*max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);

        // Back-to-back multiplies with start held through DONE
        run_op("MUL b2b 1",     3'b000, 32'h12345678, 32'h00000010, 32'h23456780, MUL_LAT);
        run_op("MUL b2b 2",     3'b000, 32'hFFFFFFFE, 32'h00000005, 32'hFFFFFFF6, MUL_LAT);
        run_op("DIV x/0",       3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, FAST_LAT);

        // Reset in the middle of a DIVU
        held = result;
        check("pre-reset result nonzero", {31'd0, (held != 32'd0)}, 32'd1);
        op = 3'b101; a = 32'd1000; b = 32'd3; start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
        end
        check("mid busy before reset", {31'd0, busy}, 32'd1);
        start = 1'b0;
        rst = 1'b1;
        #1;
        check("async reset state", {30'd0, busy, done}, 32'd0);
        check("async reset result", result, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_op("DIVU after rst", 3'b101, 32'd1000, 32'd3, 32'd333, DIV_LAT);
        run_op("REM after rst",  3'b110, 32'd1000, 32'hFFFFFFFD, 32'd1, DIV_LAT);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_mdu.md
Name: ex_mdu

Overview:
- Iterative RISC-V M-extension multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the decoded op and the two register operands held in ID/EX.
- Asserts a stall request so IF/ID and ID/EX hold while an operation runs.
- Returns one XLEN-bit result that the EX result mux forwards to EX/MEM.

Parameters:
- XLEN, 32, operand/result width; power of two, minimum 8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  abort any operation in progress; same flush as ID/EX.
- start  input  1  ID/EX holds a valid M-extension instruction.
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- stall_req  output  1  hold IF/ID and ID/EX.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse; result valid.
- result  output  XLEN  operation result.

Behaviour:
- Reset: rst is asynchronous, active-high; clk is the clock. Reset forces state IDLE and clears all of the following to 0: busy, done, result, counter, accumulators, captured op.
- States and transitions:
  - IDLE: start=1 at a clock edge captures op, a, b and the sign flags, then goes to BUSY (counter=0) or FAST.
  - BUSY: one iteration per cycle; counter increments; after XLEN iterations goes to DONE.
  - FAST: divide special cases only; goes to DONE on the next edge.
  - DONE: done=1 and result is driven for exactly one cycle; then IDLE.
- stall_req = start & ~done (combinational). It is high from the first cycle start is seen until the DONE cycle, where it drops so the instruction advances that same edge. start is ignored in BUSY, FAST and DONE.
- Latency:
  - Normal: done rises XLEN+1 cycles after the first cycle start is high (33 for XLEN=32).
  - FAST path: done rises 2 cycles after start.
- Back-to-back operations: a new start seen in IDLE right after DONE begins a new operation with no bubble beyond that IDLE cycle.
- Multiply:
  - Shift-add on operand magnitudes.
  - Signedness: a is signed for MUL, MULH and MULHSU; b is signed for MUL and MULH.
  - The 2*XLEN-bit product is negated if exactly one signed operand is negative.
  - MUL returns the low half; the other three ops return the high half.
- Divide:
  - Restoring division on magnitudes.
  - Quotient sign = sign(a) xor sign(b), applied only for DIV.
  - Remainder takes the sign of a, applied only for REM.
- Divide special cases (take the FAST path):
  - b==0: DIV/DIVU result = all ones; REM/REMU result = a.
  - DIV/REM with a=INT_MIN and b=-1: DIV result = INT_MIN; REM result = 0.
- flush: in any state, next edge goes to IDLE; done is not asserted; result is held. flush has priority over start.
- Reset mid-operation: immediately IDLE; no done pulse.
- Operands are captured at start; later changes on a or b do not affect the operation in progress.
- result holds its last value after DONE until the next DONE.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: the multiply ops compute the full product with a single-cycle combinational multiplier and go IDLE -> FAST -> DONE, so done comes 2 cycles after start. Divide behaviour is unchanged.
- Undefined: multiply uses the XLEN-iteration shift-add path. No multiplier is inferred.

Test Plan:
- Reset asserted mid-BUSY (DIVU in progress) -> busy=0, done=0, result=0 immediately; a later start runs normally.
- MUL with a=0xFFFFFFFF (-1), b=0x00000003 -> result=0xFFFFFFFD, done at cycle 33 (cycle 2 with MDU_FAST_MUL_EN); stall_req high on every cycle before done, low on the done cycle. Also MULHU with the same operands -> 0x00000002; MULHSU -> 0xFFFFFFFF.
- DIV with a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD (-3); REM with the same operands -> 0xFFFFFFFF (-1); DIVU with a=100, b=7 -> 14; REMU with the same operands -> 2.
- DIVU with a=5, b=0 -> 0xFFFFFFFF, done on cycle 2; REM with a=0x80000000, b=0xFFFFFFFF -> 0; DIV with the same operands -> 0x80000000, done on cycle 2.
- flush pulsed at iteration 10 of a DIV -> next cycle IDLE, no done pulse, stall_req follows start; new MULHU with a=b=0xFFFFFFFF -> 0xFFFFFFFE.
- Two consecutive MUL instructions (start held through DONE, then the next op) -> the first start is ignored during DONE; the second is captured in the following IDLE cycle; both results are correct.
